mem_responder: RTL
==================

# mem_responder

Synchronous 16-word × 8-bit memory that serves the accumulator CPU's memory traffic over a req/ack handshake. It acts as the responder for the CPU's fetch, indirect-address, load, store and in-memory operations (double, complement), which complete as atomic read-modify-writes. A side load port preloads program and data words before or between runs. It sits between the CPU core and the test bench or loader.

## Interface
- ADDR_W, 4, address width; depth is 2^ADDR_W words
- DATA_W, 8, word width
- WAIT_STATES, 0, extra cycles inserted between request acceptance and the access (0–7)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  1  request strobe; requester holds it high until it sees ack
- cmd  in  2  00 read, 01 write, 10 RMW double (M = M + M), 11 RMW complement (M = ~M)
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data; used only when cmd = 01
- rdata  out  DATA_W  read data; old word for reads and RMW, unchanged for writes
- ack  out  1  one-cycle completion pulse
- busy  out  1  high from request acceptance through the ack cycle
- ld_en  in  1  preload strobe
- ld_addr  in  ADDR_W  preload address
- ld_data  in  DATA_W  preload data

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - If ld_en = 1: write M[ld_addr] = ld_data. req is not accepted that cycle because load has priority; a held req is accepted on the first IDLE cycle with ld_en = 0.
  - Else if req = 1: latch cmd, addr and wdata, load wait counter = WAIT_STATES, set busy = 1, go to WAIT.
- **WAIT**
  - If the counter is non-zero, decrement it and stay in WAIT.
  - If the counter is 0, perform the access with the latched fields, drive rdata and ack = 1, go to RESP.
    - read: rdata = M[a].
    - write: M[a] = wdata; rdata holds its previous value.
    - double: rdata = M[a]; M[a] = (M[a] << 1) mod 2^DATA_W. The carry is discarded.
    - complement: rdata = M[a]; M[a] = ~M[a].
- **RESP**
  - ack = 1 and busy = 1 for this cycle only; next state is IDLE.
  - req is ignored in RESP. The requester drops req on seeing ack. A req still high in the following IDLE cycle is treated as a new request.
- ld_en outside IDLE is ignored; no write occurs.
- Request fields are latched at acceptance. Changes to cmd, addr or wdata while busy have no effect.
- rdata holds its last value until the next read or RMW completes.
- **Reset** (rst = 1 at a clock edge, in any state including mid-transaction):
  - state = IDLE, counter = 0, ack = 0, busy = 0, rdata = 0.
  - All 2^ADDR_W words are cleared to 0.
  - Any in-flight access is abandoned with no memory update and no ack.
  - rst has priority over ld_en and req.

## Timing
- Acceptance edge = E.
- ack is high in the cycle after edge E + 1 + WAIT_STATES.
- Memory update and rdata change take effect at that same edge.
- Read latency is WAIT_STATES + 1 cycles from acceptance.
- Minimum request spacing is WAIT_STATES + 3 cycles: accept, wait or access, RESP, then IDLE accept.
- busy rises at edge E and falls at the edge ending RESP.
- ack is never high for two consecutive cycles.
- An RMW is atomic: no preload or other request can interleave between its read and its write.

## Test plan
- **Reset and preload:** assert rst for 1 cycle, then preload M[3] = 8'h5A. Read addr 3 → ack one cycle after acceptance with rdata = 8'h5A. Read addr 4 → rdata = 8'h00.
- **Write then read, WAIT_STATES = 2:** write 8'hC3 to addr 9, then read addr 9. Each ack arrives exactly 3 cycles after acceptance, and rdata = 8'hC3. During the write's ack, rdata is unchanged from its previous value.
- **RMW wrap:** preload M[2] = 8'h81, issue double. rdata = 8'h81, then a read gives 8'h02. Issue complement on M[2] → rdata = 8'h02, then a read gives 8'hFD.
- **Load priority:** in IDLE, hold ld_en = 1 (M[0] = 8'h11) and req = 1 (read addr 0) in the same cycle. The load happens first, the request is accepted the next cycle, and rdata = 8'h11. ld_en pulsed while busy leaves memory unchanged.
- **Reset mid-transaction:** accept a write of 8'hFF to addr 5 with WAIT_STATES = 3, then assert rst during WAIT. ack never pulses, busy = 0, and a later read of addr 5 returns 8'h00.
- **Held req / back-to-back:** keep req high through ack with cmd = read and addr changing from 1 to 6 after acceptance. The first response reflects addr 1, and a second request is accepted in the IDLE cycle after RESP using addr 6.

Source files
------------

// File: rtl/mem_responder.sv
// 2^ADDR_W x DATA_W synchronous memory with req/ack access and atomic RMW.
// A side preload port writes words while the responder is idle.
module mem_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_DBL = 2'b10;
    localparam logic [1:0] CMD_CPL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] cur;

    assign cur   = mem_q[addr_q];
    assign rdata = rdata_q;
    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);

    // Next-state, request latching and the single-edge memory access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (ld_en) begin
                    mem_d[ld_addr] = ld_data;
                end else if (req) begin
                    cmd_d   = cmd;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WS;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = RESP;
                    unique case (cmd_q)
                        CMD_RD: rdata_d = cur;
                        CMD_WR: mem_d[addr_q] = wdata_q;
                        CMD_DBL: begin
                            rdata_d       = cur;
                            mem_d[addr_q] = {cur[DATA_W-2:0], 1'b0};
                        end
                        CMD_CPL: begin
                            rdata_d       = cur;
                            mem_d[addr_q] = ~cur;
                        end
                        default: rdata_d = rdata_q;
                    endcase
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and storage registers; reset clears every word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end

endmodule
